// File: rtl/tdm_demux8.sv
// tdm_demux8: receive side of a serial TDM link.
// Collects one bit per enabled clock into a shadow register, tracks the slot
// position with a two-state FSM, and publishes each complete frame on dout
// with a one-cycle frame_valid pulse. Sync problems give a one-cycle frame_err.
// Optional build macro TDM_PARITY_EN adds an even-parity slot after the last
// data slot. In that build the slot counter and the slot output are one bit wider.
module tdm_demux8 #(
  parameter int LANES = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             din,
  output logic [LANES-1:0] dout,
  output logic             frame_valid,
  output logic             frame_err,
`ifdef TDM_PARITY_EN
  output logic [SELW:0]    slot,
`else
  output logic [SELW-1:0]  slot,
`endif
  output logic             locked
);

`ifdef TDM_PARITY_EN
  localparam int CW = SELW + 1;
`else
  localparam int CW = SELW;
`endif

  // Index of the last data slot. With parity enabled, the parity slot follows it.
  localparam logic [CW-1:0] LAST_DATA = CW'(LANES - 1);
`ifdef TDM_PARITY_EN
  localparam logic [CW-1:0] PAR_SLOT  = CW'(LANES);
`endif
  localparam logic [CW-1:0] SLOT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [LANES-1:0] shadow;

  // Frame tracking FSM.
  // Every registered output is updated here, so the outputs never glitch.
  // frame_valid and frame_err are cleared by default on every edge, which
  // makes them single-cycle pulses even when en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      slot        <= '0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (sync) begin
              shadow <= {{(LANES-1){1'b0}}, din};
              slot   <= SLOT_ONE;
              state  <= RUN;
              locked <= 1'b1;
            end
          end
          RUN: begin
            if (slot == '0) begin
              if (sync) begin
                shadow <= {{(LANES-1){1'b0}}, din};
                slot   <= SLOT_ONE;
              end else begin
                // A missing sync at a frame boundary means the link has lost lock.
                frame_err <= 1'b1;
                state     <= IDLE;
                locked    <= 1'b0;
                slot      <= '0;
              end
            end else if (sync) begin
              // An early sync discards the partial frame and starts a new one with this bit.
              frame_err <= 1'b1;
              shadow    <= {{(LANES-1){1'b0}}, din};
              slot      <= SLOT_ONE;
`ifdef TDM_PARITY_EN
            end else if (slot == LAST_DATA) begin
              shadow[LANES-1] <= din;
              slot            <= PAR_SLOT;
            end else if (slot == PAR_SLOT) begin
              // Even parity: the parity bit equals the XOR of the data bits.
              if (din == ^shadow) begin
                dout        <= shadow;
                frame_valid <= 1'b1;
              end else begin
                frame_err   <= 1'b1;
              end
              slot <= '0;
`else
            end else if (slot == LAST_DATA) begin
              dout        <= {din, shadow[LANES-2:0]};
              frame_valid <= 1'b1;
              slot        <= '0;
`endif
            end else begin
              shadow[slot[SELW-1:0]] <= din;
              slot                   <= slot + SLOT_ONE;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
            slot   <= '0;
          end
        endcase
      end
    end
  end

endmodule
